note_sequencer: RTL and testbench

//  Song sequencer feeding the buzzer tone generator. Walks a synchronous note ROM at a fixed

---
 rtl/note_sequencer.sv | 134 +++++++++++++
 tb/tb_note_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Song sequencer: walks a registered note ROM at a fixed tempo with an articulation gap.
// Define SEQ_LOOP_EN to restart the song automatically instead of stopping at the end.
module note_sequencer #(
   parameter int          ADDR_W    = 8,
   parameter int          TEMPO_DIV = 4194304,
   parameter int          GAP_DIV   = 262144,
   parameter logic [7:0]  END_CODE  = 8'hFF
) (
   input  logic              clk0,
   input  logic              rst,
   input  logic              play_tgl_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [7:0]        rom_data_i,
   output logic [7:0]        note_out_o,
   output logic              note_valid_o,
   output logic              playing_o,
   output logic              song_end_o
);

   localparam int CNT_W = $clog2(TEMPO_DIV);
   localparam logic [CNT_W-1:0] HOLD_LAST =
      CNT_W'(TEMPO_DIV - GAP_DIV - 1);
   // FETCH and LATCH make up the last two gap cycles
   localparam logic [CNT_W-1:0] GAP_LAST =
      CNT_W'(GAP_DIV - 3);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      HOLD,
      GAP
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  step_cnt_q;
   logic [ADDR_W-1:0] rom_addr_q;
   logic [7:0]        note_q;
   logic              valid_q;
   logic              playing_q;
   logic              song_end_q;

   logic end_now;
   logic stop_now;

   assign stop_now = play_tgl_i && (state_q != IDLE);
   assign end_now  =
      ((state_q == LATCH) && (rom_data_i == END_CODE)) ||
      ((state_q == GAP) && (step_cnt_q == GAP_LAST) &&
       (rom_addr_q == LAST_ADDR));

   always_ff @(posedge clk0 or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         step_cnt_q <= '0;
         rom_addr_q <= '0;
         note_q     <= '0;
         valid_q    <= 1'b0;
         playing_q  <= 1'b0;
         song_end_q <= 1'b0;
      end else begin
         song_end_q <= 1'b0;
         if (stop_now) begin
            state_q    <= IDLE;
            step_cnt_q <= '0;
            rom_addr_q <= '0;
            valid_q    <= 1'b0;
            playing_q  <= 1'b0;
         end else if (end_now) begin
            song_end_q <= 1'b1;
            valid_q    <= 1'b0;
            rom_addr_q <= '0;
            step_cnt_q <= '0;
`ifdef SEQ_LOOP_EN
            state_q    <= FETCH;
`else
            state_q    <= IDLE;
            playing_q  <= 1'b0;
`endif
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (play_tgl_i) begin
                     rom_addr_q <= '0;
                     step_cnt_q <= '0;
                     playing_q  <= 1'b1;
                     state_q    <= FETCH;
                  end
               end
               FETCH: begin
                  step_cnt_q <= '0;
                  state_q    <= LATCH;
               end
               LATCH: begin
                  note_q     <= rom_data_i;
                  valid_q    <= (rom_data_i != 8'd0);
                  step_cnt_q <= '0;
                  state_q    <= HOLD;
               end
               HOLD: begin
                  if (step_cnt_q == HOLD_LAST) begin
                     valid_q    <= 1'b0;
                     step_cnt_q <= '0;
                     state_q    <= GAP;
                  end else begin
                     step_cnt_q <= step_cnt_q + 1'b1;
                  end
               end
               GAP: begin
                  if (step_cnt_q == GAP_LAST) begin
                     rom_addr_q <= rom_addr_q + 1'b1;
                     step_cnt_q <= '0;
                     state_q    <= FETCH;
                  end else begin
                     step_cnt_q <= step_cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q    <= IDLE;
                  step_cnt_q <= '0;
               end
            endcase
         end
      end
   end

   assign rom_addr_o   = rom_addr_q;
   assign note_out_o   = note_q;
   assign note_valid_o = valid_q;
   assign playing_o    = playing_q;
   assign song_end_o   = song_end_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a small registered ROM model.
// Timing is counted in rising edges after the play_tgl sampling edge E0.
module tb_note_sequencer;

   logic       clk0 = 1'b0;
   logic       rst  = 1'b0;
   logic       play_tgl = 1'b0;
   logic [2:0] rom_addr;
   logic [7:0] rom_data = 8'd0;
   logic [7:0] note_out;
   logic       note_valid;
   logic       playing;
   logic       song_end;

   logic [7:0] rom [8];
   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk0 = ~clk0;

   always_ff @(posedge clk0) rom_data <= rom[rom_addr];

   note_sequencer #(
      .ADDR_W(3), .TEMPO_DIV(16), .GAP_DIV(4), .END_CODE(8'hFF)
   ) dut (
      .clk0(clk0),
      .rst(rst),
      .play_tgl_i(play_tgl),
      .rom_addr_o(rom_addr),
      .rom_data_i(rom_data),
      .note_out_o(note_out),
      .note_valid_o(note_valid),
      .playing_o(playing),
      .song_end_o(song_end)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic pulse();
      play_tgl = 1'b1;
      @(negedge clk0);
      play_tgl = 1'b0;
      cyc = 0;
   endtask

   task automatic adv(input int k);
      while (cyc < k) begin
         @(negedge clk0);
         cyc++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(negedge clk0);
      @(negedge clk0);
      rst = 1'b1;
   endtask

   task automatic load_song();
      rom[0] = 8'd25; rom[1] = 8'd27; rom[2] = 8'd0;
      rom[3] = 8'd30; rom[4] = 8'hFF; rom[5] = 8'd40;
      rom[6] = 8'd41; rom[7] = 8'd42;
   endtask

   initial begin
      load_song();
      #1;
      chk("rst_addr", 32'(rom_addr), 0);
      chk("rst_note", 32'(note_out), 0);
      chk("rst_valid", 32'(note_valid), 0);
      chk("rst_play", 32'(playing), 0);
      chk("rst_end", 32'(song_end), 0);
      @(negedge clk0);
      @(negedge clk0);
      rst = 1'b1;
      @(negedge clk0);

      // first note and step timing
      pulse();
      chk("e0_addr", 32'(rom_addr), 0);
      chk("e0_play", 32'(playing), 1);
      chk("e0_valid", 32'(note_valid), 0);
      adv(1);
      chk("e1_valid", 32'(note_valid), 0);
      adv(2);
      chk("e2_note", 32'(note_out), 25);
      chk("e2_valid", 32'(note_valid), 1);
      adv(13);
      chk("e13_valid", 32'(note_valid), 1);
      adv(14);
      chk("e14_valid", 32'(note_valid), 0);
      chk("e14_note", 32'(note_out), 25);
      adv(17);
      chk("e17_addr", 32'(rom_addr), 1);
      chk("e17_valid", 32'(note_valid), 0);
      adv(18);
      chk("e18_note", 32'(note_out), 27);
      chk("e18_valid", 32'(note_valid), 1);

      // rest step
      adv(34);
      chk("rest_note", 32'(note_out), 0);
      chk("rest_valid", 32'(note_valid), 0);
      adv(40);
      chk("rest_mid", 32'(note_valid), 0);
      adv(50);
      chk("s3_note", 32'(note_out), 30);
      chk("s3_valid", 32'(note_valid), 1);

      // end code at address 4
      adv(65);
      chk("pre_end", 32'(song_end), 0);
      chk("pre_addr", 32'(rom_addr), 4);
      adv(66);
      chk("end_pulse", 32'(song_end), 1);
      chk("end_addr", 32'(rom_addr), 0);
      chk("end_valid", 32'(note_valid), 0);
`ifdef SEQ_LOOP_EN
      chk("end_play", 32'(playing), 1);
      adv(67);
      chk("end_once", 32'(song_end), 0);
      adv(68);
      chk("loop_note", 32'(note_out), 25);
      chk("loop_valid", 32'(note_valid), 1);
`else
      chk("end_play", 32'(playing), 0);
      adv(67);
      chk("end_once", 32'(song_end), 0);
      adv(70);
      chk("idle_valid", 32'(note_valid), 0);
      chk("idle_play", 32'(playing), 0);
`endif

      // song without end code: ends after address 7
      do_reset();
      for (int i = 0; i < 8; i++) rom[i] = 8'(10 + i);
      @(negedge clk0);
      pulse();
      adv(114);
      chk("a7_note", 32'(note_out), 17);
      chk("a7_addr", 32'(rom_addr), 7);
      adv(127);
      chk("a7_gap_end", 32'(song_end), 0);
      chk("a7_gap_addr", 32'(rom_addr), 7);
      adv(128);
      chk("a7_end", 32'(song_end), 1);
      chk("a7_wrap", 32'(rom_addr), 0);
`ifdef SEQ_LOOP_EN
      chk("a7_play", 32'(playing), 1);
`else
      chk("a7_play", 32'(playing), 0);
`endif
      adv(129);
      chk("a7_once", 32'(song_end), 0);

      // stop mid-hold
      do_reset();
      load_song();
      @(negedge clk0);
      pulse();
      adv(8);
      chk("hold_valid", 32'(note_valid), 1);
      pulse();
      chk("stop_valid", 32'(note_valid), 0);
      chk("stop_play", 32'(playing), 0);
      chk("stop_addr", 32'(rom_addr), 0);
      chk("stop_note", 32'(note_out), 25);
      chk("stop_end", 32'(song_end), 0);
      adv(5);
      chk("stop_stay", 32'(playing), 0);

      // asynchronous reset mid-step
      pulse();
      adv(6);
      chk("ar_pre", 32'(note_valid), 1);
      #2 rst = 1'b0;
      #1;
      chk("ar_valid", 32'(note_valid), 0);
      chk("ar_note", 32'(note_out), 0);
      chk("ar_play", 32'(playing), 0);
      chk("ar_addr", 32'(rom_addr), 0);
      @(negedge clk0);
      rst = 1'b1;
      @(negedge clk0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
